// File: rtl/aperture_xlate.sv
// aperture_xlate
// Picks the lowest-indexed aperture that hits, translates the A8 address
// into an SDRAM byte address, and runs one req/ack transaction per A8 bus
// cycle. Read data goes back to the A8 bus mux. A timeout stops a hung
// controller from stalling the bus.

module aperture_xlate #(
    parameter int          NUM_AP   = 16,
    parameter int          TIMEOUT  = 64,
    parameter logic [7:0]  CFG_PAGE = 8'hD6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a8_rw_n,
    input  logic [15:0]           a8_addr,
    input  logic [7:0]            a8_data,
    input  logic                  aValid,
    input  logic                  wValid,
    input  logic [NUM_AP-1:0]     apHit,
    input  logic [32*NUM_AP-1:0]  apBase,
    input  logic [8*NUM_AP-1:0]   apLo,
    output logic                  sdReq,
    output logic                  sdWe,
    output logic [31:0]           sdAddr,
    output logic [7:0]            sdWData,
    input  logic                  sdAck,
    input  logic [7:0]            sdRData,
    output logic [7:0]            rdData,
    output logic                  rdValid,
    output logic                  busy,
    output logic                  timeoutErr
);

    localparam int IDX_W = (NUM_AP > 1) ? $clog2(NUM_AP) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              hit_s;
    logic              start_s;
    logic [IDX_W-1:0]  sel_s;
    logic [31:0]       base_sel_s;
    logic [7:0]        lo_sel_s;
    logic [7:0]        off_s;
    logic [31:0]       xlate_s;

    // Lowest set bit wins; scanning downward leaves the smallest index last.
    function automatic logic [IDX_W-1:0] pick_lowest(input logic [NUM_AP-1:0] hits);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = NUM_AP - 1; i >= 0; i--) begin
            if (hits[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Decode qualifier, winner selection and address translation.
    always_comb begin
        hit_s      = (|apHit) & (a8_addr[15:8] != CFG_PAGE);
        sel_s      = pick_lowest(apHit);
        base_sel_s = apBase[{sel_s, 5'b00000} +: 32];
        lo_sel_s   = apLo[{sel_s, 3'b000} +: 8];
        off_s      = a8_addr[15:8] - lo_sel_s;
        xlate_s    = base_sel_s + {16'h0000, off_s, a8_addr[7:0]};
        if (aValid && hit_s && (a8_rw_n || wValid)) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            sdReq      <= 1'b0;
            sdWe       <= 1'b0;
            sdAddr     <= 32'h0000_0000;
            sdWData    <= 8'h00;
            rdData     <= 8'hFF;
            rdValid    <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            timeoutErr <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    rdValid <= 1'b0;
                    if (start_s) begin
                        state_r <= ST_REQ;
                        sdReq   <= 1'b1;
                        sdAddr  <= xlate_s;
                        sdWe    <= ~a8_rw_n;
                        if (!a8_rw_n) begin
                            sdWData <= a8_data;
                        end else begin
                            sdWData <= sdWData;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (sdAck) begin
                        // An ack in the last allowed cycle still wins over the timeout.
                        state_r <= ST_DONE;
                        sdReq   <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                        if (!sdWe) begin
                            rdData <= sdRData;
                        end else begin
                            rdData <= rdData;
                        end
                    end else if (cnt_r == CNT_LAST) begin
                        state_r    <= ST_DONE;
                        sdReq      <= 1'b0;
                        cnt_r      <= {CNT_W{1'b0}};
                        timeoutErr <= 1'b1;
                        if (!sdWe) begin
                            rdData <= 8'hFF;
                        end else begin
                            rdData <= rdData;
                        end
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    // Stay here for the rest of the A8 cycle so only one
                    // transaction is issued per bus cycle.
                    if (aValid) begin
                        rdValid <= ~sdWe;
                    end else begin
                        state_r <= ST_IDLE;
                        rdValid <= 1'b0;
                        rdData  <= 8'hFF;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    sdReq   <= 1'b0;
                    rdValid <= 1'b0;
                    rdData  <= 8'hFF;
                end
            endcase
        end
    end

    assign busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_aperture_xlate.sv
// Randomized bench for aperture_xlate with a transaction-level reference model.

module tb_aperture_xlate;

    localparam int         NUM_AP   = 16;
    localparam int         TIMEOUT  = 64;
    localparam logic [7:0] CFG_PAGE = 8'hD6;

    logic                  clk;
    logic                  rst;
    logic                  a8_rw_n;
    logic [15:0]           a8_addr;
    logic [7:0]            a8_data;
    logic                  aValid;
    logic                  wValid;
    logic [NUM_AP-1:0]     apHit;
    logic [32*NUM_AP-1:0]  apBase;
    logic [8*NUM_AP-1:0]   apLo;
    logic                  sdReq;
    logic                  sdWe;
    logic [31:0]           sdAddr;
    logic [7:0]            sdWData;
    logic                  sdAck;
    logic [7:0]            sdRData;
    logic [7:0]            rdData;
    logic                  rdValid;
    logic                  busy;
    logic                  timeoutErr;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [31:0] base_m [NUM_AP];
    logic [7:0]  lo_m   [NUM_AP];

    aperture_xlate #(.NUM_AP(NUM_AP), .TIMEOUT(TIMEOUT), .CFG_PAGE(CFG_PAGE)) dut (
        .clk(clk), .rst(rst), .a8_rw_n(a8_rw_n), .a8_addr(a8_addr), .a8_data(a8_data),
        .aValid(aValid), .wValid(wValid), .apHit(apHit), .apBase(apBase), .apLo(apLo),
        .sdReq(sdReq), .sdWe(sdWe), .sdAddr(sdAddr), .sdWData(sdWData), .sdAck(sdAck),
        .sdRData(sdRData), .rdData(rdData), .rdValid(rdValid), .busy(busy),
        .timeoutErr(timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_aps();
        for (int i = 0; i < NUM_AP; i++) begin
            apBase[32*i +: 32] = base_m[i];
            apLo[8*i +: 8]     = lo_m[i];
        end
    endtask

    function automatic bit model_hit(input logic [15:0] hits, input logic [15:0] addr);
        return (hits != 16'h0000) && (addr[15:8] != CFG_PAGE);
    endfunction

    function automatic logic [31:0] model_addr(input logic [15:0] hits, input logic [15:0] addr);
        int         w;
        logic [7:0] off;
        w = -1;
        for (int i = 0; i < NUM_AP; i++) begin
            if (hits[i] && w < 0) w = i;
        end
        if (w < 0) return 32'h0;
        off = addr[15:8] - lo_m[w];
        return base_m[w] + {16'h0000, off, addr[7:0]};
    endfunction

    task automatic check_reset_state(input string tag);
        check_val({tag, "_sdreq"},  32'(sdReq), 32'(1'b0));
        check_val({tag, "_sdwe"},   32'(sdWe), 32'(1'b0));
        check_val({tag, "_sdaddr"}, sdAddr, 32'h0);
        check_val({tag, "_wdata"},  32'(sdWData), 32'h0);
        check_val({tag, "_rddata"}, 32'(rdData), 32'hFF);
        check_val({tag, "_rdvld"},  32'(rdValid), 32'(1'b0));
        check_val({tag, "_tmo"},    32'(timeoutErr), 32'(1'b0));
        check_val({tag, "_busy"},   32'(busy), 32'(1'b0));
    endtask

    // One A8 bus cycle. ack_at: REQ cycle carrying sdAck (0 = never).
    task automatic run_txn(input bit rw_n, input logic [15:0] addr, input logic [7:0] wdata,
                           input logic [15:0] hits, input int wdelay, input int ack_at,
                           input bit drop);
        logic [31:0] exp_addr;
        logic [7:0]  exp_rd;
        int          req_cycles;
        int          exp_cycles;
        int          hold;
        load_aps();
        exp_addr = model_addr(hits, addr);
        apHit    = hits;
        a8_addr  = addr;
        a8_rw_n  = rw_n;
        a8_data  = 8'($urandom);
        aValid   = 1'b1;
        wValid   = 1'b0;
        if (!model_hit(hits, addr)) begin
            wValid  = !rw_n;
            a8_data = wdata;
            repeat (3) begin
                tick();
                check_val("nohit_sdreq", 32'(sdReq), 32'(1'b0));
                check_val("nohit_busy", 32'(busy), 32'(1'b0));
            end
            aValid = 1'b0;
            wValid = 1'b0;
            tick();
            return;
        end
        if (!rw_n) begin
            repeat (wdelay) begin
                tick();
                check_val("wwait_sdreq", 32'(sdReq), 32'(1'b0));
            end
            wValid  = 1'b1;
            a8_data = wdata;
        end
        tick();
        check_val("start_sdreq", 32'(sdReq), 32'(1'b1));
        check_val("start_busy", 32'(busy), 32'(1'b1));
        check_val("start_addr", sdAddr, exp_addr);
        check_val("start_we", 32'(sdWe), 32'(!rw_n));
        if (!rw_n) check_val("start_wdata", 32'(sdWData), 32'(wdata));
        // Disturb the decode inputs after capture.
        apHit   = 16'($urandom);
        apBase  = {16{$urandom}};
        apLo    = {4{$urandom}};
        wValid  = 1'b0;
        a8_data = 8'($urandom);
        if (drop) aValid = 1'b0;
        exp_cycles = (ack_at >= 1 && ack_at <= TIMEOUT) ? ack_at : TIMEOUT;
        exp_rd     = 8'hFF;
        req_cycles = 0;
        while (sdReq === 1'b1 && req_cycles < TIMEOUT + 4) begin
            req_cycles++;
            sdRData = 8'($urandom);
            sdAck   = (req_cycles == ack_at);
            if (sdAck && rw_n) exp_rd = sdRData;
            tick();
            sdAck = 1'b0;
            check_val("tmo_pulse", 32'(timeoutErr),
                      32'(req_cycles == TIMEOUT && ack_at != TIMEOUT));
        end
        check_val("req_len", 32'(req_cycles), 32'(exp_cycles));
        check_val("held_addr", sdAddr, exp_addr);
        check_val("held_we", 32'(sdWe), 32'(!rw_n));
        if (!rw_n) check_val("held_wdata", 32'(sdWData), 32'(wdata));
        check_val("done_busy", 32'(busy), 32'(1'b1));
        check_val("done_rdvld0", 32'(rdValid), 32'(1'b0));
        check_val("done_rddata", 32'(rdData), 32'(exp_rd));
        if (drop) begin
            tick();
            check_val("drop_busy", 32'(busy), 32'(1'b0));
            check_val("drop_rdvld", 32'(rdValid), 32'(1'b0));
            check_val("drop_tmo", 32'(timeoutErr), 32'(1'b0));
        end else begin
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) begin
                sdAck   = 1'($urandom_range(0, 1));
                sdRData = 8'($urandom);
                tick();
                sdAck = 1'b0;
                check_val("hold_rdvld", 32'(rdValid), 32'(rw_n));
                check_val("hold_rddata", 32'(rdData), 32'(exp_rd));
                check_val("hold_sdreq", 32'(sdReq), 32'(1'b0));
                check_val("hold_tmo", 32'(timeoutErr), 32'(1'b0));
            end
            aValid = 1'b0;
            tick();
            check_val("end_rdvld", 32'(rdValid), 32'(1'b0));
            check_val("end_rddata", 32'(rdData), 32'hFF);
            check_val("end_busy", 32'(busy), 32'(1'b0));
        end
        tick();
        check_val("idle_sdreq", 32'(sdReq), 32'(1'b0));
    endtask

    initial begin
        logic [15:0] r_addr;
        logic [15:0] r_hits;
        int          r_ack;
        int          sel;

        rst = 1'b1; a8_rw_n = 1'b1; a8_addr = 16'h0; a8_data = 8'h0;
        aValid = 1'b0; wValid = 1'b0; apHit = 16'h0; apBase = '0; apLo = '0;
        sdAck = 1'b0; sdRData = 8'h0;
        for (int i = 0; i < NUM_AP; i++) begin
            base_m[i] = $urandom;
            lo_m[i]   = 8'($urandom);
        end
        tick();
        tick();
        check_reset_state("rst0");
        rst = 1'b0;
        tick();

        // Read through aperture 0, ack on the 3rd REQ cycle.
        lo_m[0] = 8'h40; base_m[0] = 32'h0010_0000;
        run_txn(1'b1, 16'h4123, 8'h00, 16'h0001, 0, 3, 1'b0);
        check_val("t1_model", model_addr(16'h0001, 16'h4123), 32'h0010_0123);

        // Write, apertures 2 and 5 hit, wValid arrives late.
        lo_m[2] = 8'h80; base_m[2] = 32'hFFFF_FF80;
        lo_m[5] = 8'h00; base_m[5] = 32'h1234_0000;
        run_txn(1'b0, 16'h8000, 8'hC3, 16'h0024, 2, 1, 1'b0);

        // Read timeout, then ack exactly on the last allowed cycle.
        run_txn(1'b1, 16'h4010, 8'h00, 16'h0001, 0, 0, 1'b0);
        run_txn(1'b1, 16'h4011, 8'h00, 16'h0001, 0, TIMEOUT, 1'b0);

        // No translation: config page, or no aperture hit.
        run_txn(1'b1, 16'hD655, 8'h00, 16'h0001, 0, 1, 1'b0);
        run_txn(1'b0, 16'h1234, 8'h77, 16'h0000, 0, 1, 1'b0);

        // aValid drops during REQ; ack later.
        run_txn(1'b1, 16'h4222, 8'h00, 16'h0001, 0, 4, 1'b1);

        // Reset in the middle of a request.
        load_aps();
        apHit = 16'h0001; a8_addr = 16'h4300; a8_rw_n = 1'b1; aValid = 1'b1;
        tick();
        check_val("rstmid_sdreq_pre", 32'(sdReq), 32'(1'b1));
        tick();
        rst = 1'b1; aValid = 1'b0;
        tick();
        rst = 1'b0;
        check_reset_state("rstmid");
        sdAck = 1'b1; sdRData = 8'h3C;
        tick();
        sdAck = 1'b0;
        check_reset_state("rstmid_ack");

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NUM_AP; i++) begin
                base_m[i] = $urandom;
                lo_m[i]   = 8'($urandom);
            end
            r_addr = 16'($urandom);
            if ($urandom_range(0, 7) == 0) r_addr[15:8] = CFG_PAGE;
            sel = $urandom_range(0, 7);
            if (sel == 0) r_hits = 16'h0000;
            else if (sel == 1) r_hits = 16'h0001 << $urandom_range(0, 15);
            else r_hits = 16'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) r_ack = 0;
            else if (sel == 1) r_ack = TIMEOUT;
            else r_ack = $urandom_range(1, 6);
            run_txn(1'($urandom_range(0, 1)), r_addr, 8'($urandom), r_hits,
                    $urandom_range(0, 3), r_ack, ($urandom_range(0, 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
